// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   StallBus    - width of the per-stage stall bus
//   state_e     - controller FSM encodings (RUN/FLUSH/REFILL)
//   EXC_*       - MEM-stage exception codes presented on excepttype_i
//   STALL_*     - the only legal (prefix) stall patterns
package pipe_ctrl_pkg;

  localparam int unsigned StallBus = 6;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } state_e;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallBus-1:0] STALL_ID   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b001111;
  localparam logic [StallBus-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
//   Combines stage stall requests into a prefix stall bus and turns a
//   MEM-stage exception into a one-cycle registered flush with a redirect PC,
//   followed by a one-cycle REFILL in which new exceptions are ignored.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   stallreq_from_*     - ID / EX / MEM stall requests
//   excepttype_i        - MEM-stage exception code (0 = none)
//   cp0_epc_i           - EPC used as the eret target
//   stall               - per-stage hold (bit0 PC .. bit5 WB)
//   flush, new_pc       - registered flush pulse and redirect target
//   state_o             - FSM state for debug
//   stall_timeout_o     - sticky stall watchdog flag
// Optional feature: define PIPE_CTRL_STALL_WATCHDOG_EN to build the stall
// watchdog; otherwise stall_timeout_o is tied low.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR     = 32'h0000_0020,
  parameter int unsigned STALL_WD_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_id,
  input  logic                stallreq_from_ex,
  input  logic                stallreq_from_mem,
  input  logic [31:0]         excepttype_i,
  input  logic [31:0]         cp0_epc_i,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic [1:0]          state_o,
  output logic                stall_timeout_o
);

  localparam logic [15:0] WdLimit = 16'(STALL_WD_LIMIT);

  state_e              state_q;
  logic                flush_q;
  logic [31:0]         new_pc_q;
  logic [31:0]         new_pc_d;
  logic [StallBus-1:0] stall_d;
  logic                exc_take;

  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc);
    if (code == EXC_INT)       return INT_VECTOR;
    else if (code == EXC_ERET) return epc;
    else                       return EXC_VECTOR;
  endfunction

  // Exceptions are only accepted in RUN; REFILL drops stale in-flight codes.
  assign exc_take = (state_q == RUN) && (excepttype_i != '0);
  assign new_pc_d = exc_target(excepttype_i, cp0_epc_i);

  // An accepted exception suppresses stalls: the bubble is absorbed by the flush.
  always_comb begin
    stall_d = STALL_NONE;
    if (state_q != FLUSH && !exc_take) begin
      if (stallreq_from_mem)     stall_d = STALL_MEM;
      else if (stallreq_from_ex) stall_d = STALL_EX;
      else if (stallreq_from_id) stall_d = STALL_ID;
    end
  end

  // Reset must force stall low asynchronously even though stall is combinational.
  assign stall   = rst ? STALL_NONE : stall_d;
  assign flush   = flush_q;
  assign new_pc  = new_pc_q;
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (exc_take) begin
            state_q  <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= new_pc_d;
          end
        end
        FLUSH: begin
          state_q <= REFILL;
          flush_q <= 1'b0;
        end
        REFILL: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
  logic [15:0] wd_cnt_q;
  logic [15:0] wd_cnt_d;
  logic        wd_to_q;

  // Counter saturates so a limit of 65535 is still reachable.
  always_comb begin
    wd_cnt_d = '0;
    if (stall[0] && !flush_q)
      wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == WdLimit) wd_to_q <= 1'b1;
    end
  end

  assign stall_timeout_o = wd_to_q;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WdLimit;
  assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000040: handler address for synchronous exceptions.
REQ-002 SHALL have parameter INT_VECTOR, default 32'h00000020: handler address for interrupts.
REQ-003 SHALL have parameter STALL_WD_LIMIT, default 255: consecutive-stall cycle limit for the watchdog, range 1..65535.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named as follows:
- clk  input  1  sole clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset (`RstEnable).
REQ-005 SHALL have the remaining ports:
- stallreq_from_id  input  1  ID-stage load-use stall request.
- stallreq_from_ex  input  1  EX-stage multi-cycle (mult/div/madd) stall request.
- stallreq_from_mem  input  1  MEM-stage memory-wait stall request.
- excepttype_i  input  32  MEM-stage exception code; 0 means none.
- cp0_epc_i  input  32  current CP0 EPC, used for eret.
- stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  output  1  registered pipeline flush.
- new_pc  output  32  registered redirect target, valid while flush=1.
- state_o  output  2  current FSM state, for debug.
- stall_timeout_o  output  1  sticky watchdog flag.

Function
REQ-006 SHALL implement a three-state FSM: RUN=2'd0, FLUSH=2'd1, REFILL=2'd2.
REQ-007 SHALL, in RUN with excepttype_i!=0, move to FLUSH on the next edge and register flush=1 and new_pc.
REQ-008 SHALL select new_pc from excepttype_i as follows:
- 32'h1 -> INT_VECTOR.
- 32'he (eret) -> cp0_epc_i sampled on the same edge.
- any other nonzero code (8, a, c, d, ...) -> EXC_VECTOR.
REQ-009 SHALL keep FLUSH for exactly one cycle, then go to REFILL; in FLUSH, flush=1, stall=6'b000000, and all requests are ignored.
REQ-010 SHALL keep REFILL for exactly one cycle, then go to RUN; in REFILL, flush=0, excepttype_i is ignored so a stale in-flight code cannot flush twice, and stall requests are honoured.
REQ-011 SHALL, in RUN and REFILL, drive stall combinationally with this priority:
- stallreq_from_mem -> 6'b011111.
- else stallreq_from_ex -> 6'b001111.
- else stallreq_from_id -> 6'b000111.
- else 6'b000000.
REQ-012 SHALL give an exception in RUN priority over any simultaneous stall request: stall is 6'b000000 in that cycle, so the bubble is absorbed by the flush.
REQ-013 SHALL hold flush=0 and new_pc unchanged whenever the FSM is not in FLUSH.
REQ-014 SHALL never produce a non-prefix stall pattern; only the four encodings in REQ-011 are legal.

Reset
REQ-015 SHALL, while rst=1 and asynchronously, force:
- state=RUN, flush=0, new_pc=32'h0, stall=6'b000000;
- the watchdog counter to 0 and stall_timeout_o=0.
REQ-016 SHALL, if reset asserts in FLUSH or REFILL, abandon the redirect and restart in RUN with no flush issued.

Configuration
REQ-017 SHALL gate the watchdog with macro PIPE_CTRL_STALL_WATCHDOG_EN.
REQ-018 SHALL, with the macro defined, behave as follows:
- A 16-bit counter increments each cycle stall[0]=1 and clears on any cycle stall[0]=0 or flush=1.
- When the counter reaches STALL_WD_LIMIT, stall_timeout_o sets and stays 1 until reset.
- stall values are never altered by the watchdog.
REQ-019 SHALL, with the macro undefined, tie stall_timeout_o to 0 and implement no counter logic; the port remains present.

Structure
REQ-020 SHALL take `StallBus width, FSM state encodings, exception codes (EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET) and the stall encodings from defines.v.
REQ-021 SHALL be a single module with no sub-modules; the exception-to-vector mapping is an internal combinational function.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- stallreq_from_ex=1 for 10 cycles, no exception -> stall=6'b001111 for exactly those 10 cycles; flush stays 0.
- stallreq_from_id=1 and stallreq_from_mem=1 together -> stall=6'b011111.
- excepttype_i=32'h8 in RUN -> next cycle flush=1, new_pc=32'h40; one cycle later flush=0 and state_o=REFILL; then state_o=RUN.
- excepttype_i=32'he, cp0_epc_i=32'h00001234, with stallreq_from_mem=1 in the same cycle -> stall=0 that cycle; next cycle flush=1, new_pc=32'h00001234.
- excepttype_i=32'h1 held for 3 cycles -> exactly one flush pulse with new_pc=32'h20; no second flush during REFILL.
- Macro defined, STALL_WD_LIMIT=4, stallreq_from_ex=1 held -> stall_timeout_o rises after the 4th stalled cycle and stays 1 after the request drops; rst clears it; asserting rst during FLUSH clears flush within the same cycle.
